// File: rtl/usb_ep_trans_fifo.sv
// Transactional endpoint byte FIFO: speculative write/read pointers with commit,
// rollback (write side) and rewind (read side) on transaction-done pulses.
module usb_ep_trans_fifo #(
  parameter int unsigned EP_ADDR_WID = 9,
  parameter int unsigned EP_DATA_WID = 8
) (
  input  logic                   clk48_i,
  input  logic                   rst_n_i,
  input  logic [EP_DATA_WID-1:0] fillData_i,
  input  logic                   dataValid_i,
  input  logic                   fillTransDone_i,
  input  logic                   fillTransSuccess_i,
  output logic                   full_o,
  output logic                   overflow_o,
  input  logic                   popData_i,
  input  logic                   popTransDone_i,
  input  logic                   popTransSuccess_i,
  output logic                   dataAvailable_o,
  output logic [EP_DATA_WID-1:0] data_o,
  output logic [EP_ADDR_WID:0]   level_o
);

  localparam int unsigned Depth = 2 ** EP_ADDR_WID;
  localparam int unsigned PtrW  = EP_ADDR_WID + 1;

  typedef logic [PtrW-1:0] ptr_t;

  ptr_t wr_tmp_q, wr_tmp_d;
  ptr_t wr_commit_q, wr_commit_d;
  ptr_t rd_tmp_q, rd_tmp_d;
  ptr_t rd_commit_q, rd_commit_d;
  logic wr_err_q, wr_err_d;
  logic overflow_q, overflow_d;

  logic [EP_DATA_WID-1:0] mem [Depth];

  ptr_t wr_used;
  logic full;
  logic avail;
  logic wr_en;
  logic rd_en;

  // Unreleased (read but not yet acknowledged) entries still occupy space.
  assign wr_used = wr_tmp_q - rd_commit_q;
  assign full    = (wr_used == ptr_t'(Depth));
  assign avail   = (rd_tmp_q != wr_commit_q);
  assign wr_en   = dataValid_i & ~full;
  assign rd_en   = popData_i & avail;

  always_comb begin
    wr_tmp_d    = wr_tmp_q;
    wr_commit_d = wr_commit_q;
    wr_err_d    = wr_err_q;
    overflow_d  = dataValid_i & full;
    if (wr_en) begin
      wr_tmp_d = wr_tmp_q + ptr_t'(1);
    end
    if (dataValid_i && full) begin
      wr_err_d = 1'b1;
    end
    if (fillTransDone_i) begin
      wr_err_d = 1'b0;
      if (fillTransSuccess_i && !wr_err_q) begin
        wr_commit_d = wr_tmp_d;
      end else begin
        wr_tmp_d = wr_commit_q;
      end
    end
  end

  always_comb begin
    rd_tmp_d    = rd_tmp_q;
    rd_commit_d = rd_commit_q;
    if (rd_en) begin
      rd_tmp_d = rd_tmp_q + ptr_t'(1);
    end
    if (popTransDone_i) begin
      if (popTransSuccess_i) begin
        rd_commit_d = rd_tmp_d;
      end else begin
        rd_tmp_d = rd_commit_q;
      end
    end
  end

  always_ff @(posedge clk48_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wr_tmp_q    <= '0;
      wr_commit_q <= '0;
      rd_tmp_q    <= '0;
      rd_commit_q <= '0;
      wr_err_q    <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      wr_tmp_q    <= wr_tmp_d;
      wr_commit_q <= wr_commit_d;
      rd_tmp_q    <= rd_tmp_d;
      rd_commit_q <= rd_commit_d;
      wr_err_q    <= wr_err_d;
      overflow_q  <= overflow_d;
    end
  end

  // A write slot beyond wr_commit is never visible, so a same-cycle rollback is harmless here.
  always_ff @(posedge clk48_i) begin
    if (wr_en) begin
      mem[wr_tmp_q[EP_ADDR_WID-1:0]] <= fillData_i;
    end
  end

  assign full_o          = full;
  assign overflow_o      = overflow_q;
  assign dataAvailable_o = avail;
  assign data_o          = mem[rd_tmp_q[EP_ADDR_WID-1:0]];
  assign level_o         = wr_commit_q - rd_commit_q;

endmodule

// File: tb/tb_usb_ep_trans_fifo.sv
// Scoreboard bench for usb_ep_trans_fifo with a 4-entry FIFO.
module tb_usb_ep_trans_fifo;

  localparam int AW    = 2;
  localparam int DW    = 8;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [DW-1:0] fill_data;
  logic          data_valid;
  logic          fill_done;
  logic          fill_succ;
  logic          full;
  logic          overflow;
  logic          pop_data;
  logic          pop_done;
  logic          pop_succ;
  logic          avail;
  logic [DW-1:0] data;
  logic [AW:0]   level;

  int vectors     = 0;
  int miscompares = 0;

  logic [DW-1:0] sb[$];    // committed, unreleased bytes in order
  logic [DW-1:0] pend[$];  // bytes of the open write transaction
  int            rd_idx = 0;
  bit            werr   = 1'b0;

  always #5 clk = ~clk;

  usb_ep_trans_fifo #(
    .EP_ADDR_WID(AW),
    .EP_DATA_WID(DW)
  ) dut (
    .clk48_i           (clk),
    .rst_n_i           (rst_n),
    .fillData_i        (fill_data),
    .dataValid_i       (data_valid),
    .fillTransDone_i   (fill_done),
    .fillTransSuccess_i(fill_succ),
    .full_o            (full),
    .overflow_o        (overflow),
    .popData_i         (pop_data),
    .popTransDone_i    (pop_done),
    .popTransSuccess_i (pop_succ),
    .dataAvailable_o   (avail),
    .data_o            (data),
    .level_o           (level)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_state(input string tag);
    bit exp_avail;
    exp_avail = (rd_idx < sb.size());
    check({tag, ".avail"}, 32'(avail), 32'(exp_avail));
    check({tag, ".level"}, 32'(level), 32'(sb.size()));
    check({tag, ".full"}, 32'(full), 32'((sb.size() + pend.size()) == DEPTH));
    if (exp_avail) check({tag, ".data"}, 32'(data), 32'(sb[rd_idx]));
  endtask

  task automatic write_byte(input logic [DW-1:0] b);
    bit f;
    f = ((sb.size() + pend.size()) == DEPTH);
    fill_data  = b;
    data_valid = 1'b1;
    step();
    data_valid = 1'b0;
    if (f) werr = 1'b1;
    else pend.push_back(b);
    check("wr.ovf", 32'(overflow), 32'(f));
  endtask

  task automatic end_fill(input bit s, input string tag);
    fill_done = 1'b1;
    fill_succ = s;
    step();
    fill_done = 1'b0;
    fill_succ = 1'b0;
    if (s && !werr) foreach (pend[i]) sb.push_back(pend[i]);
    pend.delete();
    werr = 1'b0;
    check_state(tag);
  endtask

  task automatic pop_byte();
    pop_data = 1'b1;
    step();
    pop_data = 1'b0;
    if (rd_idx < sb.size()) rd_idx++;
  endtask

  task automatic end_pop(input bit s, input string tag);
    pop_done = 1'b1;
    pop_succ = s;
    step();
    pop_done = 1'b0;
    pop_succ = 1'b0;
    if (s) repeat (rd_idx) void'(sb.pop_front());
    rd_idx = 0;
    check_state(tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n      = 1'b0;
    fill_data  = '0;
    data_valid = 1'b0;
    fill_done  = 1'b0;
    fill_succ  = 1'b0;
    pop_data   = 1'b0;
    pop_done   = 1'b0;
    pop_succ   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst.full", 32'(full), 32'(0));
    check("rst.avail", 32'(avail), 32'(0));
    check("rst.level", 32'(level), 32'(0));
    check("rst.ovf", 32'(overflow), 32'(0));
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // Commit then drain.
    write_byte(8'h11);
    write_byte(8'h22);
    write_byte(8'h33);
    check_state("commit.pre");
    end_fill(1'b1, "commit");
    check("commit.d0", 32'(data), 32'(8'h11));
    check("commit.lvl", 32'(level), 32'(3));
    repeat (3) begin
      check_state("commit.pop");
      pop_byte();
    end
    check("commit.empty", 32'(avail), 32'(0));
    end_pop(1'b1, "commit.rel");

    // Write rollback.
    write_byte(8'hAA);
    write_byte(8'hBB);
    end_fill(1'b0, "rollback");
    write_byte(8'h01);
    end_fill(1'b1, "rollback.next");
    check("rollback.d", 32'(data), 32'(8'h01));
    pop_byte();
    end_pop(1'b1, "rollback.rel");

    // Read rewind.
    write_byte(8'h10);
    write_byte(8'h20);
    end_fill(1'b1, "rewind.fill");
    pop_byte();
    pop_byte();
    end_pop(1'b0, "rewind");
    check("rewind.d", 32'(data), 32'(8'h10));
    pop_byte();
    pop_byte();
    end_pop(1'b1, "rewind.rel");
    check("rewind.lvl", 32'(level), 32'(0));

    // Zero-length transactions.
    end_fill(1'b1, "zlp.fill");
    end_pop(1'b1, "zlp.pop");

    // Full and overflow.
    for (int i = 0; i < DEPTH; i++) write_byte(8'(8'h40 + i));
    check("ovf.full", 32'(full), 32'(1));
    write_byte(8'h99);
    step();
    check("ovf.clear", 32'(overflow), 32'(0));
    end_fill(1'b1, "ovf.rollback");
    check("ovf.lvl", 32'(level), 32'(0));

    // Space held by unreleased reads keeps full asserted until release.
    for (int i = 0; i < DEPTH; i++) write_byte(8'(8'h60 + i));
    end_fill(1'b1, "hold.fill");
    pop_byte();
    check_state("hold.pop");
    end_pop(1'b0, "hold.rewind");
    pop_byte();
    end_pop(1'b1, "hold.rel");

    // Drain the remaining three bytes.
    repeat (3) pop_byte();
    end_pop(1'b1, "hold.drain");

    // Wrap-around.
    for (int it = 0; it < 10; it++) begin
      for (int k = 0; k < 3; k++) write_byte(8'(it * 3 + k + 1));
      end_fill(1'b1, "wrap.fill");
      for (int k = 0; k < 3; k++) begin
        check_state("wrap.pop");
        pop_byte();
      end
      end_pop(1'b1, "wrap.rel");
    end

    // Commit and release in the same cycle.
    write_byte(8'hC1);
    end_fill(1'b1, "same.fill");
    pop_byte();
    write_byte(8'hC2);
    fill_done = 1'b1;
    fill_succ = 1'b1;
    pop_done  = 1'b1;
    pop_succ  = 1'b1;
    step();
    fill_done = 1'b0;
    fill_succ = 1'b0;
    pop_done  = 1'b0;
    pop_succ  = 1'b0;
    repeat (rd_idx) void'(sb.pop_front());
    rd_idx = 0;
    foreach (pend[i]) sb.push_back(pend[i]);
    pend.delete();
    check("same.lvl", 32'(level), 32'(1));
    check_state("same");
    pop_byte();
    end_pop(1'b1, "same.rel");

    // Asynchronous reset in the middle of both transactions.
    write_byte(8'h77);
    end_fill(1'b1, "arst.fill");
    pop_byte();
    write_byte(8'h88);
    data_valid = 1'b1;
    fill_data  = 8'h89;
    pop_data   = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    check("arst.full", 32'(full), 32'(0));
    check("arst.avail", 32'(avail), 32'(0));
    check("arst.level", 32'(level), 32'(0));
    check("arst.ovf", 32'(overflow), 32'(0));
    data_valid = 1'b0;
    pop_data   = 1'b0;
    sb.delete();
    pend.delete();
    rd_idx = 0;
    werr   = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    step();
    check_state("arst.post");
    write_byte(8'h5A);
    end_fill(1'b1, "arst.commit");
    check("arst.d", 32'(data), 32'(8'h5A));
    pop_byte();
    end_pop(1'b1, "arst.rel");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
